// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding and default-width command/response records.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH     = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     strb;
    logic [2:0]                prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, no bypass: a full FIFO refuses a push even on a same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; the flags and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb4_master_engine.sv
// APB4 master: queued valid/ready commands become APB transfers; results return via a 2-entry response queue.
module apb4_master_engine
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  // Same layout as apb_cmd_t/apb_rsp_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    logic [2:0]            prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  cmd_t       cmd_in, cmd_head;
  rsp_t       rsp_in, rsp_head;
  logic       cmd_full, cmd_empty;
  logic       rsp_full, rsp_empty;
  logic       complete, abort, finish, rsp_pop, launch;
  logic [2:0] rsp_occ_next;

  apb_state_e    state_q;
  logic [CW-1:0] acc_cnt_q;

  assign cmd_in = '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata,
                    strb: cmd_strb, prot: cmd_prot};

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (cmd_valid),
    .wdata_i (cmd_in),
    .pop_i   (launch),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign complete = (state_q == ACCESS) && pready;
  assign abort    = TO_EN && (state_q == ACCESS) && !pready && (acc_cnt_q == TO_LAST);
  assign finish   = complete || abort;

  assign rsp_in = '{rdata:   (complete && !pwrite) ? prdata : '0,
                    err:     complete ? pslverr : 1'b1,
                    timeout: !complete};

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(2)) u_rsp_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (finish),
    .wdata_i (rsp_in),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  // Launch only if the response queue will hold at most one entry after this edge,
  // so the eventual completion always finds room.
  assign rsp_pop      = rsp_valid && rsp_ready;
  assign rsp_occ_next = {1'b0, rsp_full, !rsp_empty && !rsp_full} + 3'(finish) - 3'(rsp_pop);
  assign launch       = !cmd_empty && ((state_q == IDLE) || finish) && (rsp_occ_next <= 3'd1);

  assign cmd_ready   = presetn && !cmd_full;
  assign rsp_valid   = !rsp_empty;
  assign rsp_rdata   = rsp_valid ? rsp_head.rdata : '0;
  assign rsp_err     = rsp_valid && rsp_head.err;
  assign rsp_timeout = rsp_valid && rsp_head.timeout;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else if (launch) begin
      state_q   <= SETUP;
      acc_cnt_q <= '0;
      psel      <= 1'b1;
      penable   <= 1'b0;
      pwrite    <= cmd_head.write;
      paddr     <= cmd_head.addr;
      pwdata    <= cmd_head.wdata;
      pstrb     <= cmd_head.write ? cmd_head.strb : '0;
      pprot     <= cmd_head.prot;
    end else begin
      case (state_q)
        SETUP: begin
          state_q <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (finish) begin
            state_q <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end else if (acc_cnt_q != '1) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_engine.sv
// Randomized bench: a transaction-level model predicts APB bus activity, queue backpressure and responses.
module tb_apb4_master_engine;
  import apb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 8;

  logic          pclk, presetn;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  apb4_master_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model of what sits in the engine: pending commands, pending responses, transfer on the bus.
  apb_cmd_t mq[$];
  apb_rsp_t rq[$];
  apb_cmd_t cur;
  bit       bus_sel, bus_en;
  int       acc_n;
  bit       cmd_acc;

  // Stimulus knobs, percentages; force_at > 0 raises pready only in that ACCESS cycle.
  int p_cmd, p_rsp, p_pready, p_err, force_at;

  task automatic model_cycle();
    apb_rsp_t r;
    bit       fin, rpop, launch;
    int       occ;
    check("cmd_ready", cmd_ready, mq.size() < DEPTH);
    check("psel", psel, bus_sel);
    check("penable", penable, bus_en);
    if (bus_sel) begin
      check("paddr", paddr, cur.addr);
      check("pwrite", pwrite, cur.write);
      check("pwdata", pwdata, cur.wdata);
      check("pstrb", pstrb, cur.write ? cur.strb : 4'h0);
      check("pprot", pprot, cur.prot);
    end
    check("rsp_valid", rsp_valid, rq.size() != 0);
    if (rq.size() != 0) begin
      check("rsp_rdata", rsp_rdata, rq[0].rdata);
      check("rsp_err", rsp_err, rq[0].err);
      check("rsp_timeout", rsp_timeout, rq[0].timeout);
    end
    rpop = (rq.size() != 0) && rsp_ready;
    fin  = bus_en && (pready || acc_n == TO);
    r    = '0;
    if (fin) begin
      r.rdata   = (pready && !cur.write) ? prdata : '0;
      r.err     = pready ? pslverr : 1'b1;
      r.timeout = !pready;
    end
    occ     = rq.size() + int'(fin) - int'(rpop);
    launch  = (mq.size() != 0) && (!bus_sel || fin) && occ <= 1;
    cmd_acc = cmd_valid && (mq.size() < DEPTH);
    if (rpop) void'(rq.pop_front());
    if (fin) rq.push_back(r);
    if (launch) begin
      cur = mq.pop_front();
      bus_sel = 1'b1; bus_en = 1'b0;
    end else if (bus_sel && !bus_en) begin
      bus_en = 1'b1; acc_n = 1;
    end else if (bus_en) begin
      if (fin) begin bus_sel = 1'b0; bus_en = 1'b0; end
      else acc_n++;
    end
    if (cmd_acc) mq.push_back('{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata,
                                strb: cmd_strb, prot: cmd_prot});
  endtask

  task automatic drive();
    if (!cmd_valid || cmd_acc) begin
      cmd_valid = $urandom_range(0, 99) < p_cmd;
      cmd_addr  = $urandom;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom_range(0, 15));
      cmd_prot  = 3'($urandom_range(0, 7));
    end
    rsp_ready = $urandom_range(0, 99) < p_rsp;
    prdata    = $urandom;
    pslverr   = $urandom_range(0, 99) < p_err;
    if (force_at > 0) pready = bus_en && (acc_n == force_at);
    else              pready = $urandom_range(0, 99) < p_pready;
  endtask

  task automatic step();
    @(negedge pclk);
    model_cycle();
    @(posedge pclk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mode(input int c, input int r, input int p, input int e, input int f);
    p_cmd = c; p_rsp = r; p_pready = p; p_err = e; force_at = f;
  endtask

  task automatic put_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] pr);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = pr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {psel, penable, pwrite, pprot, pstrb, cmd_ready}, '0);
    check({tag, "_paddr"}, paddr, '0);
    check({tag, "_pwdata"}, pwdata, '0);
    check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
  endtask

  initial begin
    bit hit;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    bus_sel = 1'b0; bus_en = 1'b0; acc_n = 0; cmd_acc = 1'b0; cur = '0;
    mode(0, 100, 100, 0, 0);
    #3;
    check_reset_outputs("reset");
    @(posedge pclk); @(posedge pclk); #1;
    presetn = 1'b1;
    drive();

    // Single write, zero wait states.
    put_cmd(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
    run(8);
    // Read with three wait states (pready in the 4th ACCESS cycle).
    mode(0, 100, 0, 0, 4);
    put_cmd(32'h20, 1'b0, 32'h0, 4'hF, 3'b000);
    run(12);
    // Back-to-back burst.
    mode(100, 100, 100, 0, 0);
    run(6);
    mode(0, 100, 100, 0, 0);
    run(12);
    // Watchdog expiry, engine stalled so the command queue fills.
    mode(60, 100, 0, 0, 0);
    run(60);
    mode(0, 100, 0, 0, 0);
    run(60);
    // pready exactly in the last permitted ACCESS cycle.
    mode(40, 100, 0, 30, TO);
    run(80);
    // Response backpressure: two transfers finish, the rest wait.
    mode(100, 0, 100, 0, 0);
    run(20);
    mode(0, 100, 100, 100, 0);
    run(20);
    // Random mix.
    mode(50, 60, 60, 20, 0);
    run(3000);

    // Reset while a transfer is in ACCESS.
    mode(80, 50, 0, 0, 0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = bus_en;
    end
    check("reach_access", hit, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    mq.delete(); rq.delete();
    bus_sel = 1'b0; bus_en = 1'b0; cmd_acc = 1'b0;
    cmd_valid = 1'b0;
    mode(0, 100, 100, 0, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    drive();
    run(20);
    mode(50, 70, 70, 20, 0);
    run(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb4_master_engine.md
Name: apb4_master_engine

Overview:
- Parametrised APB4 master that turns a valid/ready command stream into APB transfers and returns a valid/ready response stream.
- Extends the plain APB signal set with PSTRB and PPROT, a command queue, back-to-back transfers and a PREADY timeout watchdog.
- Sits between register-access sequencers or CPU-side logic and the APB fabric; the VIP monitor observes its APB side.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- CMD_DEPTH, 4, command queue entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- pclk  in  1  APB clock; the only clock.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue not full.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- paddr, psel, penable, pwrite, pwdata, pstrb, pprot  out  per widths  APB4 request signals.
- pready  in  1  APB completer ready.
- prdata  in  DATA_WIDTH  APB read data.
- pslverr  in  1  APB error.

Behaviour:
- Reset: presetn low clears all outputs asynchronously: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_* all 0, and cmd_ready 0 while presetn is low.
  - Both queues are flushed and the FSM returns to IDLE.
  - A reset during SETUP or ACCESS abandons the transfer; no response is produced.
- Command queue:
  - Depth CMD_DEPTH; cmd_ready = !full.
  - A push happens on cmd_valid && cmd_ready.
  - No bypass: a full queue refuses a push even when a pop occurs in the same cycle.
- Response queue:
  - Depth 2; pops on rsp_valid && rsp_ready.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when the command queue is non-empty and response occupancy after this edge is ≤ 1. The command is popped on this edge and its fields are registered onto the APB outputs.
  - SETUP: psel = 1, penable = 0; lasts exactly 1 cycle, then -> ACCESS.
  - ACCESS: psel = 1, penable = 1.
    - On pready = 1, the transfer completes and a response is pushed: rdata = prdata for reads and 0 for writes, err = pslverr, timeout = 0.
    - After completion, go to SETUP under the same launch rule as IDLE (back-to-back, no idle cycle); otherwise go to IDLE.
- The launch rule guarantees the response queue always has room at completion.
- APB outputs stay stable from SETUP through the last ACCESS cycle.
  - pstrb is forced to 0 for reads.
  - After completion, psel and penable drop to 0; paddr and the other request signals hold their last value.
- Latency: a command pushed at edge N into an empty idle engine gives SETUP in cycle N+1 and ACCESS in N+2. With pready = 1 in N+2, rsp_valid = 1 from N+3.
- Watchdog (TIMEOUT_CYCLES > 0):
  - An ACCESS-cycle counter resets on entering SETUP.
  - If pready is 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts at that edge: psel and penable go to 0, and the response is rdata = 0, err = 1, timeout = 1.
  - pready = 1 in that same cycle wins and completes the transfer normally.
- The counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e (IDLE, SETUP, ACCESS);
  - apb_cmd_t struct (addr, write, wdata, strb, prot);
  - apb_rsp_t struct (rdata, err, timeout);
  - localparam STRB_WIDTH = DATA_WIDTH/8.
- Sub-module sync_fifo, parametrised by WIDTH and DEPTH with full/empty flags, is instantiated twice: for the command queue (CMD_DEPTH) and the response queue (depth 2).

Test Plan:
- Single write addr 0x10, data 0xDEADBEEF, strb 0xF, prot 3'b010, pready = 1 immediately -> psel in N+1, penable in N+2, pstrb = 0xF, pprot = 2; rsp_valid in N+3 with err = 0 and rdata = 0.
- Read at 0x20 with pready low for 3 ACCESS cycles and prdata = 0x12345678 -> penable held 4 cycles, pstrb = 0; response rdata = 0x12345678, err = 0.
- 4 commands queued, rsp_ready = 1, pready = 1 -> 4 transfers back-to-back with no IDLE cycle between them, responses in order; cmd_ready = 0 when 4 are queued with the engine stalled.
- TIMEOUT_CYCLES = 8, pready never asserted -> psel drops after 8 ACCESS cycles; response err = 1, timeout = 1, rdata = 0. A repeat with pready = 1 in cycle 8 gives a normal completion.
- rsp_ready = 0 with 3 commands queued -> exactly 2 transfers complete and the third stays in queue. After one rsp_ready pulse, the third launches; pslverr = 1 on it gives err = 1, timeout = 0.
- presetn pulsed low during ACCESS -> all APB outputs 0 asynchronously, queues empty; no stale response after reset release.
